// File: rtl/lives_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lives_pkg
// Description : Shared types and helpers for the multi-player lives tracker.
//               - chan_state_t : per-player channel state
//               - game_state_t : global match state
//               - thermometer(): LED bar pattern for a lives count
// Revision    : 1.0 - initial release
// ============================================================================
package lives_pkg;

  localparam int c_LED_WIDTH = 10;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    GRACE = 2'd1,
    DEAD  = 2'd2
  } chan_state_t;

  typedef enum logic {
    RUNNING = 1'b0,
    OVER    = 1'b1
  } game_state_t;

  // Lowest `count` bits set, clipped to `width` bits.
  function automatic logic [c_LED_WIDTH-1:0] thermometer(input int count, input int width);
    logic [c_LED_WIDTH-1:0] v_bar;
    v_bar = '0;
    for (int i = 0; i < c_LED_WIDTH; i++) begin
      v_bar[i] = (i < count) && (i < width);
    end
    return v_bar;
  endfunction

endpackage : lives_pkg
`default_nettype wire

// File: rtl/lives_channel.sv
`default_nettype none
// ============================================================================
// Module      : lives_channel
// Description : One player's lives counter with hit/bonus edge detection,
//               post-hit grace window and ARMED/GRACE/DEAD state machine.
// Ports       : clock, reset (async, active-low), restart (sync reload),
//               freeze (match over: ignore events, hold counters),
//               hit, bonus (levels), lives (count), invulnerable (in grace)
// Revision    : 1.0 - initial release
// ============================================================================
module lives_channel
  import lives_pkg::*;
#(
  parameter int MAX_LIVES      = 3,
  parameter int START_LIVES    = 3,
  parameter int GRACE_CYCLES   = 4,
  parameter int LIVES_BITWIDTH = $clog2(MAX_LIVES + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      restart,
  input  logic                      freeze,
  input  logic                      hit,
  input  logic                      bonus,
  output logic [LIVES_BITWIDTH-1:0] lives,
  output logic                      invulnerable
);

  localparam int c_GRACE_WIDTH = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam logic [c_GRACE_WIDTH-1:0]  c_GRACE_LOAD = c_GRACE_WIDTH'(GRACE_CYCLES - 1);
  localparam logic [LIVES_BITWIDTH-1:0] c_MAX        = LIVES_BITWIDTH'(MAX_LIVES);
  localparam logic [LIVES_BITWIDTH-1:0] c_START      = LIVES_BITWIDTH'(START_LIVES);
  localparam logic [LIVES_BITWIDTH-1:0] c_ONE        = LIVES_BITWIDTH'(1);

  chan_state_t                r_state, w_state_nxt;
  logic [LIVES_BITWIDTH-1:0]  r_lives, w_lives_nxt;
  logic [c_GRACE_WIDTH-1:0]   r_grace, w_grace_nxt;
  logic                       r_hit_q, r_bonus_q;
  logic                       w_hit_ev, w_bonus_ev, w_bonus_inc;

  assign w_hit_ev    = hit & ~r_hit_q;
  assign w_bonus_ev  = bonus & ~r_bonus_q;
  assign w_bonus_inc = w_bonus_ev && (r_lives != c_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_grace_nxt = r_grace;
    if (!freeze) begin
      case (r_state)
        ARMED: begin
          if (w_hit_ev && w_bonus_ev) begin
            // Hit and bonus cancel on lives, but the hit still opens a window.
            w_grace_nxt = c_GRACE_LOAD;
            w_state_nxt = GRACE;
          end else if (w_hit_ev) begin
            if (r_lives <= c_ONE) begin
              w_lives_nxt = '0;
              w_state_nxt = DEAD;
            end else begin
              w_lives_nxt = r_lives - c_ONE;
              w_grace_nxt = c_GRACE_LOAD;
              w_state_nxt = GRACE;
            end
          end else if (w_bonus_inc) begin
            w_lives_nxt = r_lives + c_ONE;
          end
        end
        GRACE: begin
          if (w_bonus_inc) begin
            w_lives_nxt = r_lives + c_ONE;
          end
          if (r_grace == '0) begin
            w_state_nxt = ARMED;
          end else begin
            w_grace_nxt = r_grace - 1'b1;
          end
        end
        default: begin
          // DEAD: terminal until restart/reset.
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ARMED;
      r_lives   <= c_START;
      r_grace   <= '0;
      r_hit_q   <= 1'b0;
      r_bonus_q <= 1'b0;
    end else if (restart) begin
      r_state   <= ARMED;
      r_lives   <= c_START;
      r_grace   <= '0;
      // Loading current levels suppresses an event for inputs held across restart.
      r_hit_q   <= hit;
      r_bonus_q <= bonus;
    end else begin
      r_state   <= w_state_nxt;
      r_lives   <= w_lives_nxt;
      r_grace   <= w_grace_nxt;
      r_hit_q   <= hit;
      r_bonus_q <= bonus;
    end
  end

  assign lives        = r_lives;
  assign invulnerable = (r_state == GRACE);

endmodule : lives_channel
`default_nettype wire

// File: rtl/lives_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lives_tracker
// Description : Multi-player lives tracker. One lives_channel per player,
//               plus alive-count reduction, global RUNNING/OVER state machine,
//               winner encoder and registered thermometer LED bar.
// Ports       : clock, reset (async, active-low), restart (sync reload),
//               hit/bonus (per-player levels), lives (packed counts),
//               alive, invulnerable, gameOver, winner, hasWinner, LEDs[9:0]
// Revision    : 1.0 - initial release
// ============================================================================
module lives_tracker
  import lives_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_LIVES      = 3,
  parameter int START_LIVES    = 3,
  parameter int GRACE_CYCLES   = 50_000_000,
  parameter int LIVES_BITWIDTH = $clog2(MAX_LIVES + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 restart,
  input  logic [NUM_PLAYERS-1:0]               hit,
  input  logic [NUM_PLAYERS-1:0]               bonus,
  output logic [NUM_PLAYERS*LIVES_BITWIDTH-1:0] lives,
  output logic [NUM_PLAYERS-1:0]               alive,
  output logic [NUM_PLAYERS-1:0]               invulnerable,
  output logic                                 gameOver,
  output logic [1:0]                           winner,
  output logic                                 hasWinner,
  output logic [c_LED_WIDTH-1:0]               LEDs
);

  generate
    if (NUM_PLAYERS * MAX_LIVES > c_LED_WIDTH) begin : g_param_check
      $fatal(1, "lives_tracker: NUM_PLAYERS*MAX_LIVES exceeds the 10-LED bar");
    end
  endgenerate

  function automatic logic [c_LED_WIDTH-1:0] start_pattern();
    logic [c_LED_WIDTH-1:0] v_pat;
    v_pat = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      v_pat = v_pat | (thermometer(START_LIVES, MAX_LIVES) << (p * MAX_LIVES));
    end
    return v_pat;
  endfunction

  localparam logic [c_LED_WIDTH-1:0] c_START_LEDS = start_pattern();

  game_state_t            r_gstate, w_gstate_nxt;
  logic                   r_has_winner, w_has_winner_nxt;
  logic [1:0]             r_winner, w_winner_nxt;
  logic [c_LED_WIDTH-1:0] r_leds, w_leds_nxt;
  logic [2:0]             w_alive_cnt;
  logic [1:0]             w_alive_idx;
  logic                   w_freeze;

  assign w_freeze = (r_gstate == OVER);

  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_channel
      lives_channel #(
        .MAX_LIVES      (MAX_LIVES),
        .START_LIVES    (START_LIVES),
        .GRACE_CYCLES   (GRACE_CYCLES),
        .LIVES_BITWIDTH (LIVES_BITWIDTH)
      ) u_channel (
        .clock        (clock),
        .reset        (reset),
        .restart      (restart),
        .freeze       (w_freeze),
        .hit          (hit[p]),
        .bonus        (bonus[p]),
        .lives        (lives[p*LIVES_BITWIDTH +: LIVES_BITWIDTH]),
        .invulnerable (invulnerable[p])
      );
      assign alive[p] = |lives[p*LIVES_BITWIDTH +: LIVES_BITWIDTH];
    end
  endgenerate

  always_comb begin
    w_alive_cnt = '0;
    w_alive_idx = '0;
    w_leds_nxt  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_alive_cnt = w_alive_cnt + 3'(alive[p]);
      if (alive[p]) begin
        w_alive_idx = 2'(p);
      end
      w_leds_nxt = w_leds_nxt |
                   (thermometer(int'(lives[p*LIVES_BITWIDTH +: LIVES_BITWIDTH]), MAX_LIVES)
                    << (p * MAX_LIVES));
    end
  end

  always_comb begin
    w_gstate_nxt     = r_gstate;
    w_has_winner_nxt = r_has_winner;
    w_winner_nxt     = r_winner;
    case (r_gstate)
      RUNNING: begin
        // A single-player game only ends when that player is out.
        if ((w_alive_cnt == 3'd0) || ((w_alive_cnt <= 3'd1) && (NUM_PLAYERS > 1))) begin
          w_gstate_nxt     = OVER;
          w_has_winner_nxt = (w_alive_cnt == 3'd1) && (NUM_PLAYERS > 1);
          w_winner_nxt     = w_alive_idx;
        end
      end
      default: begin
        // OVER: results hold until restart/reset.
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gstate     <= RUNNING;
      r_has_winner <= 1'b0;
      r_winner     <= '0;
      r_leds       <= c_START_LEDS;
    end else if (restart) begin
      r_gstate     <= RUNNING;
      r_has_winner <= 1'b0;
      r_winner     <= '0;
      r_leds       <= c_START_LEDS;
    end else begin
      r_gstate     <= w_gstate_nxt;
      r_has_winner <= w_has_winner_nxt;
      r_winner     <= w_winner_nxt;
      r_leds       <= w_leds_nxt;
    end
  end

  assign gameOver  = (r_gstate == OVER);
  assign hasWinner = r_has_winner;
  assign winner    = r_winner;
  assign LEDs      = r_leds;

endmodule : lives_tracker
`default_nettype wire

// File: tb/tb_lives_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lives_tracker
// Description : Self-checking bench for lives_tracker (2 players, 3 lives,
//               4-cycle grace). Directed test-plan steps followed by random
//               hit/bonus/restart traffic, all compared to a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lives_tracker;

  localparam int NP = 2;
  localparam int ML = 3;
  localparam int SL = 3;
  localparam int GC = 4;
  localparam int LB = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            restart = 1'b0;
  logic [NP-1:0]   hit = '0;
  logic [NP-1:0]   bonus = '0;
  logic [NP*LB-1:0] lives;
  logic [NP-1:0]   alive;
  logic [NP-1:0]   invulnerable;
  logic            gameOver;
  logic [1:0]      winner;
  logic            hasWinner;
  logic [9:0]      LEDs;

  lives_tracker #(
    .NUM_PLAYERS    (NP),
    .MAX_LIVES      (ML),
    .START_LIVES    (SL),
    .GRACE_CYCLES   (GC),
    .LIVES_BITWIDTH (LB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .restart      (restart),
    .hit          (hit),
    .bonus        (bonus),
    .lives        (lives),
    .alive        (alive),
    .invulnerable (invulnerable),
    .gameOver     (gameOver),
    .winner       (winner),
    .hasWinner    (hasWinner),
    .LEDs         (LEDs)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Behavioural model: lives per player, remaining invulnerable cycles,
  // dead flag, previous input samples, and match result.
  int            m_lives [NP];
  int            m_grace [NP];
  bit            m_dead  [NP];
  logic [NP-1:0] m_prev_hit, m_prev_bonus;
  bit            m_over, m_hw;
  int            m_win;
  logic [9:0]    m_leds;

  function automatic logic [9:0] bar_from_model();
    logic [9:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      v = v | (((10'd1 << m_lives[p]) - 10'd1) << (p * ML));
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_lives[p] = SL;
      m_grace[p] = 0;
      m_dead[p]  = 0;
    end
    m_prev_hit   = '0;
    m_prev_bonus = '0;
    m_over = 0;
    m_hw   = 0;
    m_win  = 0;
    m_leds = bar_from_model();
  endtask

  // Computes the state right after the coming clock edge from current inputs.
  task automatic model_edge();
    int n_alive, idx;
    bit hev, bev, old_over;
    if (restart) begin
      model_reset();
      m_prev_hit   = hit;
      m_prev_bonus = bonus;
      return;
    end
    n_alive = 0;
    idx = 0;
    for (int p = 0; p < NP; p++) begin
      if (m_lives[p] > 0) begin
        n_alive++;
        idx = p;
      end
    end
    old_over = m_over;
    m_leds = bar_from_model();
    if (!m_over && (n_alive == 0 || (n_alive <= 1 && NP > 1))) begin
      m_over = 1;
      m_hw   = (n_alive == 1);
      m_win  = idx;
    end
    if (!old_over) begin
      for (int p = 0; p < NP; p++) begin
        hev = hit[p] && !m_prev_hit[p];
        bev = bonus[p] && !m_prev_bonus[p];
        if (m_dead[p]) begin
          // nothing
        end else if (m_grace[p] > 0) begin
          m_grace[p]--;
          if (bev && m_lives[p] < ML) m_lives[p]++;
        end else if (hev) begin
          if (bev) begin
            m_grace[p] = GC;
          end else if (m_lives[p] <= 1) begin
            m_lives[p] = 0;
            m_dead[p]  = 1;
          end else begin
            m_lives[p]--;
            m_grace[p] = GC;
          end
        end else if (bev && m_lives[p] < ML) begin
          m_lives[p]++;
        end
      end
    end
    m_prev_hit   = hit;
    m_prev_bonus = bonus;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [NP-1:0] e_alive, e_inv;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s lives%0d", where, p), 32'(lives[p*LB +: LB]), 32'(m_lives[p]));
      e_alive[p] = (m_lives[p] > 0);
      e_inv[p]   = (m_grace[p] > 0);
    end
    check({where, " alive"}, 32'(alive), 32'(e_alive));
    check({where, " invulnerable"}, 32'(invulnerable), 32'(e_inv));
    check({where, " gameOver"}, 32'(gameOver), 32'(m_over));
    check({where, " hasWinner"}, 32'(hasWinner), 32'(m_hw));
    check({where, " winner"}, 32'(winner), 32'(m_win));
    check({where, " LEDs"}, 32'(LEDs), 32'(m_leds));
  endtask

  task automatic step(input logic [NP-1:0] h, input logic [NP-1:0] b, input logic r,
                      input string where);
    hit = h;
    bonus = b;
    restart = r;
    model_edge();
    @(posedge clock);
    #1;
    check_all(where);
  endtask

  initial begin
    logic [NP-1:0] rh, rb;
    logic          rr;

    // Reset state
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    check("reset LEDs const", 32'(LEDs), 32'(10'b0000111111));
    check("reset lives const", 32'(lives), 32'(4'b1111));
    reset = 1'b1;

    // P0 hit, ignored hit during grace, hit accepted at cycle 5
    step(2'b01, 2'b00, 1'b0, "p0 hit");
    check("p0 after hit", 32'(lives[1:0]), 32'd2);
    step(2'b00, 2'b00, 1'b0, "grace1");
    step(2'b01, 2'b00, 1'b0, "grace hit");
    step(2'b00, 2'b00, 1'b0, "grace3");
    step(2'b00, 2'b00, 1'b0, "grace4");
    check("p0 grace-ignored hit", 32'(lives[1:0]), 32'd2);
    step(2'b01, 2'b00, 1'b0, "p0 hit cycle5");
    check("p0 second hit", 32'(lives[1:0]), 32'd1);
    step(2'b00, 2'b00, 1'b0, "idle");

    // P1 saturation, then hit + bonus
    step(2'b00, 2'b10, 1'b0, "p1 bonus");
    step(2'b00, 2'b00, 1'b0, "idle");
    step(2'b00, 2'b10, 1'b0, "p1 bonus");
    step(2'b00, 2'b00, 1'b0, "idle");
    check("p1 saturated", 32'(lives[3:2]), 32'd3);
    step(2'b10, 2'b00, 1'b0, "p1 hit");
    step(2'b00, 2'b00, 1'b0, "idle");
    step(2'b00, 2'b10, 1'b0, "p1 bonus in grace");
    step(2'b00, 2'b00, 1'b0, "idle");
    check("p1 hit then bonus", 32'(lives[3:2]), 32'd3);

    // P0 at one life: simultaneous hit and bonus
    step(2'b01, 2'b01, 1'b0, "p0 hit+bonus");
    check("p0 hit+bonus lives", 32'(lives[1:0]), 32'd1);
    check("p0 hit+bonus invuln", 32'(invulnerable[0]), 32'd1);
    step(2'b00, 2'b00, 1'b0, "idle");
    repeat (5) step(2'b00, 2'b00, 1'b0, "pad");

    // P1 3 -> 0, hits spaced beyond the grace window
    repeat (3) begin
      step(2'b10, 2'b00, 1'b0, "p1 kill hit");
      repeat (5) step(2'b00, 2'b00, 1'b0, "p1 gap");
    end
    check("over gameOver", 32'(gameOver), 32'd1);
    check("over hasWinner", 32'(hasWinner), 32'd1);
    check("over winner", 32'(winner), 32'd0);
    step(2'b11, 2'b00, 1'b0, "hit after over");
    step(2'b00, 2'b00, 1'b0, "idle");
    check("p0 frozen", 32'(lives[1:0]), 32'd1);

    // Restart mid-grace with hit held high
    step(2'b00, 2'b00, 1'b1, "restart");
    step(2'b01, 2'b00, 1'b0, "p0 hit");
    step(2'b01, 2'b00, 1'b0, "hold");
    step(2'b01, 2'b00, 1'b1, "restart held");
    check("restart lives", 32'(lives), 32'(4'b1111));
    repeat (3) step(2'b01, 2'b00, 1'b0, "held after restart");
    check("held no decrement", 32'(lives[1:0]), 32'd3);
    step(2'b00, 2'b00, 1'b0, "release");
    step(2'b01, 2'b00, 1'b0, "rehit");
    check("rehit decrement", 32'(lives[1:0]), 32'd2);

    // Asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async reset");
    check("async lives const", 32'(lives), 32'(4'b1111));
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(2'b01, 2'b00, 1'b0, "post reset edge");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NP; p++) begin
        rh[p] = ($urandom_range(0, 3) == 0);
        rb[p] = ($urandom_range(0, 5) == 0);
      end
      rr = ($urandom_range(0, 49) == 0) || (m_over && ($urandom_range(0, 7) == 0));
      step(rh, rb, rr, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_lives_tracker
`default_nettype wire

// File: doc/lives_tracker.md
# lives_tracker

Parametrised multi-player lives tracker for the DE1-SoC game datapath. It keeps an independent lives count for each of `NUM_PLAYERS` channels and takes edge-detected hit and bonus events. After each hit it applies an invulnerability (grace) window, then drives a thermometer LED bar, per-player alive flags and a global game-over/winner result. It sits between the collision/score logic and the LED and HEX display drivers.

## Interface
- `NUM_PLAYERS`, 2: number of player channels, 1..4.
- `MAX_LIVES`, 3: saturation ceiling for lives, 1..15.
- `START_LIVES`, 3: lives loaded on reset or restart, ≤ `MAX_LIVES`.
- `GRACE_CYCLES`, 50_000_000: invulnerable cycles after a hit, ≥ 1.
- `LIVES_BITWIDTH`, `$clog2(MAX_LIVES+1)`: width of one lives field.
- `clock`, input, 1: system clock; every register is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `restart`, input, 1: synchronous reload of all channels; has priority over events.
- `hit`, input, `NUM_PLAYERS`: per-player hit level, rising-edge detected.
- `bonus`, input, `NUM_PLAYERS`: per-player extra-life level, rising-edge detected.
- `lives`, output, `NUM_PLAYERS*LIVES_BITWIDTH`: packed counts; player p is at `[p*LIVES_BITWIDTH +: LIVES_BITWIDTH]`.
- `alive`, output, `NUM_PLAYERS`: lives[p] > 0.
- `invulnerable`, output, `NUM_PLAYERS`: player in grace window.
- `gameOver`, output, 1: match finished; holds until reset or restart.
- `winner`, output, 2: index of the surviving player, valid while `gameOver` && `hasWinner`.
- `hasWinner`, output, 1: exactly one player remained alive at game over.
- `LEDs`, output, 10: thermometer display; player p uses bits `[p*MAX_LIVES +: MAX_LIVES]`, unused bits are 0.
- Elaboration: `NUM_PLAYERS*MAX_LIVES` must be ≤ 10; otherwise it is a fatal elaboration error.

## Operation
- Inputs are synchronous to `clock`. Each channel registers `hit_q`/`bonus_q`. An event is `x & ~x_q`.
- Per-channel FSM, states `ARMED`, `GRACE`, `DEAD`:
  - `ARMED`: a hit event decrements lives. If the result is 0, go to `DEAD`; otherwise load the grace counter with `GRACE_CYCLES-1` and go to `GRACE`.
  - `GRACE`: hit events are ignored and the counter decrements each cycle. At count 0, return to `ARMED` on the next edge. The window is exactly `GRACE_CYCLES` cycles.
  - `DEAD`: all events are ignored and lives hold at 0.
- Bonus events are accepted in `ARMED` and `GRACE` and increment lives, saturating at `MAX_LIVES`. A bonus does not alter the grace counter.
- A hit event and a bonus event in the same cycle on the same channel (`ARMED`): net lives unchanged, state goes to `GRACE`. A hit at 1 life with a simultaneous bonus leaves 1 life and does not kill the player.
- Global FSM, states `RUNNING`, `OVER`:
  - `RUNNING` → `OVER` when alive count is 0, or when it is ≤ 1 and `NUM_PLAYERS` > 1.
  - In `OVER`, `gameOver` is 1 and all channels freeze; events are ignored.
  - `hasWinner` and `winner` are latched on entry to `OVER`.
  - `NUM_PLAYERS==1`: game over only when the single player reaches 0; `hasWinner`=0.
- `restart` (any state): every channel goes to `ARMED` with `START_LIVES`, grace counters clear, the global FSM goes to `RUNNING`, `gameOver`/`hasWinner`/`winner` clear, and `hit_q`/`bonus_q` load the current inputs. A level held high across restart therefore produces no event.
- Reset: same values as restart, except `hit_q`/`bonus_q`=0. Outputs: `lives`=`START_LIVES` each, `alive`=all 1 if `START_LIVES`>0, `invulnerable`=0, `gameOver`=0, `winner`=0, `hasWinner`=0, `LEDs`=thermometer of `START_LIVES`.
- `START_LIVES`=0 is legal. The game goes to `OVER` on the first clock after reset with `hasWinner`=0.

## Timing
- Event input high at edge N: `lives`/`invulnerable` update at edge N (visible cycle N+1).
- `alive` is combinational from `lives`.
- `gameOver`, `winner`, `hasWinner` and `LEDs` are registered from `lives` and are visible one cycle after `lives`.
- Grace period: `invulnerable` is high for exactly `GRACE_CYCLES` cycles, starting the cycle after the hit.
- An input held high produces exactly one event. Re-arming requires one low sample.

## Structure
- Package `lives_pkg`:
  - channel state enum `{ARMED, GRACE, DEAD}`;
  - global state enum `{RUNNING, OVER}`;
  - function `thermometer(count, width)`.
- Sub-module `lives_channel` (one per player, generate loop): edge detect, lives counter, grace counter and channel FSM.
- Top level holds the alive-count reduction, the global FSM, the winner encoder and LED packing.

## Test plan
- Reset with defaults (2 players, 3 lives, `GRACE_CYCLES`=4) → `lives`=3/3, `LEDs`=10'b0000111111, `gameOver`=0.
- P0 hit pulse → P0 `lives`=2, `invulnerable[0]` high 4 cycles. A second P0 hit during grace leaves `lives`=2; a hit at cycle 5 gives `lives`=1.
- P1 at 3 lives, two bonus pulses → stays at 3 (saturation). Hit then bonus → 3.
- P0 at 1 life, hit+bonus same cycle → `lives`=1, `invulnerable[0]`=1, `alive[0]`=1.
- P1 driven 3→0 with hits spaced beyond grace → `gameOver`=1, `hasWinner`=1, `winner`=0. Further hits are ignored.
- `restart` asserted mid-grace with `hit` held high → all lives=3, `gameOver`=0, no decrement until `hit` falls and rises again. Async `reset` asserted mid-cycle clears immediately.
